// File: rtl/div_issue_pkg.sv
// Shared definitions for the divider issue block and the iterative divider it drives.
package div_issue_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    // Handshake levels agreed with the divider
    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;
    localparam logic DIV_ANNUL     = 1'b1;
    localparam logic DIV_NO_ANNUL  = 1'b0;

endpackage

// File: rtl/div_issue_hilo_reg.sv
// HI/LO architectural register pair; a completing divide wins over MTHI/MTLO.
module div_issue_hilo_reg
    import div_issue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_we,
    input  logic [DATA_W-1:0] div_hi,
    input  logic [DATA_W-1:0] div_lo,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] mt_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_we) begin
            hi <= div_hi;
            lo <= div_lo;
        end else begin
            if (mthi_we) hi <= mt_data;
            if (mtlo_we) lo <= mt_data;
        end
    end

endmodule

// File: rtl/div_issue.sv
// EX-stage initiator for the iterative divider: start/annul/ready handshake, stall and HI/LO ownership.
// Optional build macro DIV_ZERO_TRAP_EN: zero divisors are trapped here instead of being issued.
module div_issue
    import div_issue_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_req,
    input  logic                div_signed,
    input  logic [DATA_W-1:0]   src_a,
    input  logic [DATA_W-1:0]   src_b,
    input  logic                flush,
    input  logic                mthi_we,
    input  logic                mtlo_we,
    input  logic [DATA_W-1:0]   mt_data,
    output logic                div_start_o,
    output logic                div_annul_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_op1_o,
    output logic [DATA_W-1:0]   div_op2_o,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i,
    output logic                stall_req_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
`ifdef DIV_ZERO_TRAP_EN
    ,
    output logic                div_zero_o
`endif
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] drain_cnt;
    logic             accept;
    logic             div_we;
`ifdef DIV_ZERO_TRAP_EN
    logic             zero_hit;
`endif

    always_comb begin
        state_nxt   = state;
        div_start_o = DIV_STOP;
        div_annul_o = DIV_NO_ANNUL;
        stall_req_o = 1'b0;
        accept      = 1'b0;
        div_we      = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
        zero_hit    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (div_req && !flush) begin
                    accept = 1'b1;
`ifdef DIV_ZERO_TRAP_EN
                    if (src_b == '0) begin
                        zero_hit  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        stall_req_o = 1'b1;
                        state_nxt   = BUSY;
                    end
`else
                    stall_req_o = 1'b1;
                    state_nxt   = BUSY;
`endif
                end
            end
            BUSY: begin
                div_start_o = DIV_START;
                stall_req_o = (div_ready_i == DIV_NOT_READY);
                // A flush beats a same-cycle ready: the result is discarded
                if (flush) begin
                    state_nxt = DRAIN;
                end else if (div_ready_i == DIV_READY) begin
                    div_we    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // start stays low here so the divider can return to free
                stall_req_o = div_req;
                state_nxt   = IDLE;
            end
            DRAIN: begin
                div_annul_o = DIV_ANNUL;
                if (drain_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            div_signed_o <= 1'b0;
            drain_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                div_op1_o    <= src_a;
                div_op2_o    <= src_b;
                div_signed_o <= div_signed;
            end
            if (state == BUSY && flush)
                drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_zero_o <= 1'b0;
        else     div_zero_o <= zero_hit;
    end
`endif

    div_issue_hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk     (clk),
        .rst     (rst),
        .div_we  (div_we),
        .div_hi  (div_result_i[2*DATA_W-1:DATA_W]),
        .div_lo  (div_result_i[DATA_W-1:0]),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .mt_data (mt_data),
        .hi      (hi_o),
        .lo      (lo_o)
    );

endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue with a behavioural iterative-divider model and HI/LO reference.
module tb_div_issue;

    localparam int NORM_LAT = 34;
    localparam int ZERO_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req, div_signed, flush, mthi_we, mtlo_we;
    logic [31:0] src_a, src_b, mt_data;
    logic        div_start_o, div_annul_o, div_signed_o, stall_req_o;
    logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
`ifdef DIV_ZERO_TRAP_EN
    logic        div_zero_o;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    div_issue dut (
        .clk          (clk),
        .rst          (rst),
        .div_req      (div_req),
        .div_signed   (div_signed),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .mthi_we      (mthi_we),
        .mtlo_we      (mtlo_we),
        .mt_data      (mt_data),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .stall_req_o  (stall_req_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
`ifdef DIV_ZERO_TRAP_EN
        ,
        .div_zero_o   (div_zero_o)
`endif
    );

    // {remainder, quotient} with truncating division; zero divisor yields 0/0
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Divider model: counts after start, pulses ready, waits for start low to become free
    logic d_busy, d_end;
    int   d_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_busy       <= 1'b0;
            d_end        <= 1'b0;
            d_cnt        <= 0;
            div_ready_i  <= 1'b0;
            div_result_i <= '0;
        end else begin
            div_ready_i <= 1'b0;
            if (div_annul_o) begin
                d_busy <= 1'b0;
                d_end  <= 1'b0;
            end else if (d_busy) begin
                if (d_cnt <= 1) begin
                    d_busy       <= 1'b0;
                    d_end        <= 1'b1;
                    div_ready_i  <= 1'b1;
                    div_result_i <= ref_div(div_op1_o, div_op2_o, div_signed_o);
                end else begin
                    d_cnt <= d_cnt - 1;
                end
            end else if (d_end) begin
                if (!div_start_o) d_end <= 1'b0;
            end else if (div_start_o) begin
                d_busy <= 1'b1;
                d_cnt  <= (div_op2_o == 32'd0) ? ZERO_LAT : NORM_LAT;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 in IDLE; leaves the bench in the first BUSY cycle
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        div_req = 1'b1; src_a = a; src_b = b; div_signed = s;
        #1;
        check("accept_stall", stall_req_o, 1);
        check("accept_no_start", div_start_o, 0);
        tick();
        div_req = 1'b0;
        check("start_rise", div_start_o, 1);
        check("op1_latched", div_op1_o, a);
        check("op2_latched", div_op2_o, b);
        check("signed_latched", div_signed_o, s);
    endtask

    // Runs BUSY to completion; leaves the bench in the DONE cycle
    task automatic complete(input logic [63:0] res, input logic mt_hi, input int max_cyc);
        int n = 0;
        while (div_ready_i !== 1'b1 && n < max_cyc) begin
            check("busy_start_held", div_start_o, 1);
            check("busy_stall", stall_req_o, 1);
            tick();
            n++;
        end
        n_cmp++;
        assert (n < max_cyc) else begin
            n_bad++;
            $error("FAIL ready_timeout: observed %0d cycles required below %0d", n, max_cyc);
        end
        check("ready_stall_drop", stall_req_o, 0);
        if (mt_hi) begin
            mthi_we = 1'b1;
            mt_data = 32'hA5A5A5A5;
        end
        tick();
        mthi_we = 1'b0;
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        check("done_start_low", div_start_o, 0);
        check("done_hi", hi_o, exp_hi);
        check("done_lo", lo_o, exp_lo);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        rst = 1'b1; div_req = 0; div_signed = 0; flush = 0;
        mthi_we = 0; mtlo_we = 0; src_a = 0; src_b = 0; mt_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", div_start_o, 0);
        check("rst_annul", div_annul_o, 0);
        check("rst_signed", div_signed_o, 0);
        check("rst_stall", stall_req_o, 0);
        check("rst_op1", div_op1_o, 0);
        check("rst_op2", div_op2_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        rst = 1'b0;
        tick();

        // Unsigned 100/7
        issue(32'd100, 32'd7, 1'b0);
        complete(ref_div(32'd100, 32'd7, 1'b0), 1'b0, 100);
        check("u_hi_const", hi_o, 32'd2);
        check("u_lo_const", lo_o, 32'd14);
        tick();
        check("idle_start", div_start_o, 0);
        check("idle_stall", stall_req_o, 0);

        // Signed -7/2, then a back-to-back request arriving in DONE
        issue(32'hFFFFFFF9, 32'd2, 1'b1);
        complete(ref_div(32'hFFFFFFF9, 32'd2, 1'b1), 1'b0, 100);
        check("s_hi_const", hi_o, 32'hFFFFFFFF);
        check("s_lo_const", lo_o, 32'hFFFFFFFD);
        div_req = 1'b1; src_a = 32'd1000; src_b = 32'd9; div_signed = 1'b0;
        #1;
        check("b2b_done_stall", stall_req_o, 1);
        check("b2b_done_no_start", div_start_o, 0);
        tick();
        issue(32'd1000, 32'd9, 1'b0);
        complete(ref_div(32'd1000, 32'd9, 1'b0), 1'b0, 100);
        tick();

        // Randomised divides
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            rb = 32'($urandom_range(2, 5000));
            if (rs && $urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
            issue(ra, rb, rs);
            complete(ref_div(ra, rb, rs), 1'b0, 100);
            tick();
        end

        // Flush in BUSY cycle 10
        issue(32'd1000, 32'd3, 1'b0);
        repeat (9) tick();
        check("pre_flush_start", div_start_o, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        div_req = 1'b1; src_a = 32'd5; src_b = 32'd5;
        #1;
        check("drain1_annul", div_annul_o, 1);
        check("drain1_start", div_start_o, 0);
        check("drain1_stall", stall_req_o, 0);
        tick();
        check("drain2_annul", div_annul_o, 1);
        check("drain2_start", div_start_o, 0);
        check("drain2_stall", stall_req_o, 0);
        div_req = 1'b0;
        tick();
        check("post_drain_annul", div_annul_o, 0);
        check("post_drain_start", div_start_o, 0);
        check("flush_hi_kept", hi_o, exp_hi);
        check("flush_lo_kept", lo_o, exp_lo);
        issue(32'd9, 32'd3, 1'b0);
        complete(ref_div(32'd9, 32'd3, 1'b0), 1'b0, 100);
        check("after_flush_lo", lo_o, 32'd3);
        check("after_flush_hi", hi_o, 32'd0);
        tick();

        // Zero divisor 55/0
`ifdef DIV_ZERO_TRAP_EN
        div_req = 1'b1; src_a = 32'd55; src_b = 32'd0; div_signed = 1'b0;
        #1;
        check("zt_stall", stall_req_o, 0);
        tick();
        div_req = 1'b0;
        check("zt_pulse", div_zero_o, 1);
        check("zt_no_start", div_start_o, 0);
        check("zt_hi_kept", hi_o, exp_hi);
        check("zt_lo_kept", lo_o, exp_lo);
        tick();
        check("zt_pulse_end", div_zero_o, 0);
        check("zt_idle_start", div_start_o, 0);
`else
        issue(32'd55, 32'd0, 1'b0);
        complete(ref_div(32'd55, 32'd0, 1'b0), 1'b0, 10);
        check("z_hi", hi_o, 32'd0);
        check("z_lo", lo_o, 32'd0);
        tick();
`endif

        // MTHI in the ready cycle loses to the divide; MTLO/MTHI in idle write
        issue(32'd10, 32'd3, 1'b0);
        complete(ref_div(32'd10, 32'd3, 1'b0), 1'b1, 100);
        check("mthi_vs_ready_hi", hi_o, 32'd1);
        tick();
        mtlo_we = 1'b1; mt_data = 32'hA5A5A5A5;
        tick();
        mtlo_we = 1'b0;
        check("mtlo_lo", lo_o, 32'hA5A5A5A5);
        check("mtlo_hi_kept", hi_o, 32'd1);
        mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'h12345678;
        tick();
        mthi_we = 1'b0; mtlo_we = 1'b0;
        check("mt_both_hi", hi_o, 32'h12345678);
        check("mt_both_lo", lo_o, 32'h12345678);

        // Asynchronous reset in the middle of BUSY
        issue(32'hFFFF0000, 32'd3, 1'b1);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_start", div_start_o, 0);
        check("arst_stall", stall_req_o, 0);
        check("arst_annul", div_annul_o, 0);
        check("arst_signed", div_signed_o, 0);
        check("arst_op1", div_op1_o, 0);
        check("arst_op2", div_op2_o, 0);
        check("arst_hi", hi_o, 0);
        check("arst_lo", lo_o, 0);
        exp_hi = '0;
        exp_lo = '0;
        tick();
        rst = 1'b0;
        tick();
        check("arst_idle_start", div_start_o, 0);
        issue(32'd50, 32'd5, 1'b0);
        complete(ref_div(32'd50, 32'd5, 1'b0), 1'b0, 100);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
